// File: rtl/p8_seq_defs.sv
// Shared definitions for the P8 sequencer.
// Holds the program word layout, the sequencer op (sop) encodings and the
// controller state encodings. The field helpers keep bit positions in one place.
package p8_seq_defs;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned SOP_MSB = 15;
  localparam int unsigned SOP_LSB = 12;
  localparam int unsigned PAY_MSB = 11;
  localparam int unsigned PAY_LSB = 0;
  localparam int unsigned INST_W  = 12;

  typedef enum logic [3:0] {
    SEQ_ISSUE = 4'd0,
    SEQ_WAIT  = 4'd1,
    SEQ_LOOP  = 4'd2,
    SEQ_DJNZ  = 4'd3,
    SEQ_JMP   = 4'd4,
    SEQ_HALT  = 4'd5
  } sop_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StWait   = 2'd2,
    StHalted = 2'd3
  } state_e;

  function automatic logic [3:0] word_sop(input logic [WORD_W-1:0] word);
    return word[SOP_MSB:SOP_LSB];
  endfunction

  function automatic logic [INST_W-1:0] word_payload(input logic [WORD_W-1:0] word);
    return word[PAY_MSB:PAY_LSB];
  endfunction

endpackage

// File: rtl/p8_prog_mem.sv
// Program store for the P8 sequencer.
// 2**AW x WORD_W register array, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a reset.
// Ports:
//   clock  system clock
//   we     write strobe (already qualified by the controller)
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data at raddr
module p8_prog_mem
  import p8_seq_defs::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/p8_sequencer.sv
// P8 sequencer: runs a small local program that issues 12-bit
// {opcode, immediate} instructions to P8 peripherals, with wait, loop,
// jump and halt control words.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   prog_we    program write strobe, honoured only in IDLE/HALTED
//   prog_addr  program write address
//   prog_data  program word {sop[15:12], payload[11:0]}
//   start      pulse: run from address 0 (ignored while busy)
//   stop       pulse: abort a running program (beats start)
//   inst       registered peripheral instruction, holds last issued value
//   inst_en    one-cycle valid per executed ISSUE
//   busy       high in RUN and WAIT
//   done       set by HALT, cleared by start/stop
//   error      set by an illegal sop, cleared by start/stop
//   pc         current program counter
module p8_sequencer
  import p8_seq_defs::*;
#(
  parameter int unsigned PROG_AW = 4,
  parameter int unsigned WAIT_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [WORD_W-1:0]  prog_data,
  input  logic               start,
  input  logic               stop,
  output logic [INST_W-1:0]  inst,
  output logic               inst_en,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [PROG_AW-1:0] pc
);

  state_e               state_q, state_d;
  logic [PROG_AW-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0]    loop_cnt_q, loop_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [INST_W-1:0]    inst_q, inst_d;
  logic                 inst_en_q, inst_en_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic [WORD_W-1:0]    word;
  logic [3:0]           sop;
  logic [INST_W-1:0]    payload;
  logic [PROG_AW-1:0]   pc_inc;
  logic                 mem_we;

  assign mem_we = prog_we & ((state_q == StIdle) | (state_q == StHalted));

  p8_prog_mem #(
    .AW (PROG_AW)
  ) u_prog_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (word)
  );

  assign sop     = word_sop(word);
  assign payload = word_payload(word);
  assign pc_inc  = pc_q + PROG_AW'(1);  // wraps past the last word to 0

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      loop_cnt_q <= '0;
      wait_cnt_q <= '0;
      inst_q     <= '0;
      inst_en_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      inst_q     <= inst_d;
      inst_en_q  <= inst_en_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    wait_cnt_d = wait_cnt_q;
    inst_d     = inst_q;
    inst_en_d  = 1'b0;
    done_d     = done_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle, StHalted: begin
        // stop has no effect here but still masks a coincident start
        if (start && !stop) begin
          state_d = StRun;
          pc_d    = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      StRun: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b0;
          error_d = 1'b0;
        end else begin
          case (sop)
            SEQ_ISSUE: begin
              inst_d    = payload;
              inst_en_d = 1'b1;
              pc_d      = pc_inc;
            end
            SEQ_WAIT: begin
              // This cycle plus one WAIT cycle per count: 1 + N in total
              wait_cnt_d = payload[WAIT_W-1:0];
              if (payload[WAIT_W-1:0] != '0) begin
                state_d = StWait;
              end else begin
                pc_d = pc_inc;
              end
            end
            SEQ_LOOP: begin
              loop_cnt_d = payload[WAIT_W-1:0];
              pc_d       = pc_inc;
            end
            SEQ_DJNZ: begin
              if (loop_cnt_q != '0) begin
                loop_cnt_d = loop_cnt_q - WAIT_W'(1);
                pc_d       = payload[PROG_AW-1:0];
              end else begin
                pc_d = pc_inc;
              end
            end
            SEQ_JMP: begin
              pc_d = payload[PROG_AW-1:0];
            end
            SEQ_HALT: begin
              state_d = StHalted;
              done_d  = 1'b1;
            end
            default: begin
              state_d = StHalted;
              error_d = 1'b1;
              done_d  = 1'b0;
            end
          endcase
        end
      end

      StWait: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b0;
          error_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(1)) begin
            state_d = StRun;
            pc_d    = pc_inc;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q == StRun) || (state_q == StWait);
    inst    = inst_q;
    inst_en = inst_en_q;
    done    = done_q;
    error   = error_q;
    pc      = pc_q;
  end

endmodule

// File: tb/tb_p8_sequencer.sv
// Scoreboard bench for p8_sequencer: stimulus pushes the expected
// {inst, cycle} of every issue; a negedge monitor pops and compares.
module tb_p8_sequencer;
  import p8_seq_defs::*;

  localparam int unsigned PROG_AW = 4;
  localparam int unsigned WAIT_W  = 8;
  localparam logic [3:0]  LD0 = 4'h1;
  localparam logic [3:0]  LD1 = 4'h2;
  localparam logic [3:0]  LD2 = 4'h3;

  logic               clock;
  logic               reset;
  logic               prog_we;
  logic [PROG_AW-1:0] prog_addr;
  logic [15:0]        prog_data;
  logic               start;
  logic               stop;
  logic [11:0]        inst;
  logic               inst_en;
  logic               busy;
  logic               done;
  logic               error;
  logic [PROG_AW-1:0] pc;

  p8_sequencer #(
    .PROG_AW (PROG_AW),
    .WAIT_W  (WAIT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .stop      (stop),
    .inst      (inst),
    .inst_en   (inst_en),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .pc        (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] inst;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] w(input logic [3:0] op, input logic [11:0] pay);
    return {op, pay};
  endfunction

  task automatic expect_issue(input logic [11:0] i, input int c);
    exp_t e;
    e.inst = i;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    if (inst_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got inst %0h at cycle %0d, required no issue", inst, cyc);
      end else begin
        e = sb.pop_front();
        check("issue_inst", 32'(inst), 32'(e.inst));
        check("issue_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int addr, input logic [15:0] data);
    prog_we   = 1'b1;
    prog_addr = PROG_AW'(addr);
    prog_data = data;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < budget);
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  int s;

  initial begin
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    stop      = 1'b0;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    #21;
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_inst_en", 32'(inst_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // 1: back-to-back issues then halt
    load(0, w(SEQ_ISSUE, {LD0, 8'hBA}));
    load(1, w(SEQ_ISSUE, {LD1, 8'hFE}));
    load(2, w(SEQ_HALT, 12'h000));
    s = cyc;
    expect_issue({LD0, 8'hBA}, s + 2);
    expect_issue({LD1, 8'hFE}, s + 3);
    pulse_start();
    wait_idle(20, "t1_timeout");
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_pc", 32'(pc), 32'd2);
    check("t1_inst_hold", 32'(inst), 32'({LD1, 8'hFE}));
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: WAIT 3 costs 4 cycles, so issues land 5 cycles apart
    load(0, w(SEQ_ISSUE, {LD0, 8'h0A}));
    load(1, w(SEQ_WAIT, 12'd3));
    load(2, w(SEQ_ISSUE, {LD1, 8'h0B}));
    load(3, w(SEQ_HALT, 12'h000));
    s = cyc;
    expect_issue({LD0, 8'h0A}, s + 2);
    expect_issue({LD1, 8'h0B}, s + 7);
    pulse_start();
    wait_idle(30, "t2_timeout");
    check("t2_done", 32'(done), 32'd1);
    check("t2_pc", 32'(pc), 32'd3);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: LOOP 2 + DJNZ gives three passes
    load(0, w(SEQ_LOOP, 12'd2));
    load(1, w(SEQ_ISSUE, {LD2, 8'h23}));
    load(2, w(SEQ_DJNZ, 12'd1));
    load(3, w(SEQ_HALT, 12'h000));
    s = cyc;
    expect_issue({LD2, 8'h23}, s + 3);
    expect_issue({LD2, 8'h23}, s + 5);
    expect_issue({LD2, 8'h23}, s + 7);
    pulse_start();
    wait_idle(30, "t3_timeout");
    check("t3_done", 32'(done), 32'd1);
    check("t3_pc", 32'(pc), 32'd3);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: illegal sop
    load(0, 16'hF0AB);
    pulse_start();
    wait_idle(20, "t4_timeout");
    check("t4_error", 32'(error), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    check("t4_pc", 32'(pc), 32'd0);
    pulse_start();
    check("t4_restart_error_clr", 32'(error), 32'd0);
    check("t4_restart_busy", 32'(busy), 32'd1);
    wait_idle(20, "t4b_timeout");
    check("t4b_error", 32'(error), 32'd1);

    // 5a: stop during a long WAIT
    load(0, w(SEQ_WAIT, 12'd200));
    pulse_start();
    repeat (5) step();
    check("t5a_busy_before", 32'(busy), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5a_busy", 32'(busy), 32'd0);
    check("t5a_inst_en", 32'(inst_en), 32'd0);
    check("t5a_pc", 32'(pc), 32'd0);
    check("t5a_done", 32'(done), 32'd0);
    check("t5a_error", 32'(error), 32'd0);

    // 5c: start+stop together from IDLE
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("t5c_busy", 32'(busy), 32'd0);
    step();
    check("t5c_busy_later", 32'(busy), 32'd0);
    check("t5c_pc", 32'(pc), 32'd0);

    // 5b: writes while running are ignored
    load(0, w(SEQ_WAIT, 12'd20));
    load(1, w(SEQ_ISSUE, {LD0, 8'h11}));
    load(2, w(SEQ_HALT, 12'h000));
    s = cyc;
    expect_issue({LD0, 8'h11}, s + 23);
    pulse_start();
    repeat (3) step();
    load(1, w(SEQ_ISSUE, {LD0, 8'h99}));
    wait_idle(60, "t5b_timeout");
    check("t5b_done", 32'(done), 32'd1);
    check("t5b_pc", 32'(pc), 32'd2);
    s = cyc;
    expect_issue({LD0, 8'h11}, s + 23);
    pulse_start();
    wait_idle(60, "t5b_rerun_timeout");
    check("t5b_sb_empty", 32'(sb.size()), 32'd0);

    // 6: asynchronous reset mid-program, then rerun
    load(0, w(SEQ_ISSUE, {LD0, 8'hC1}));
    load(1, w(SEQ_ISSUE, {LD1, 8'hC2}));
    load(2, w(SEQ_ISSUE, {LD2, 8'hC3}));
    load(3, w(SEQ_JMP, 12'd1));
    s = cyc;
    expect_issue({LD0, 8'hC1}, s + 2);
    expect_issue({LD1, 8'hC2}, s + 3);
    expect_issue({LD2, 8'hC3}, s + 4);
    pulse_start();
    repeat (3) step();
    @(negedge clock);
    check("t6_pre_pc", 32'(pc), 32'd3);
    check("t6_pre_inst_en", 32'(inst_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_inst_en", 32'(inst_en), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_pc", 32'(pc), 32'd0);
    check("t6_rst_inst", 32'(inst), 32'd0);
    #20 reset = 1'b1;
    step();
    s = cyc;
    expect_issue({LD0, 8'hC1}, s + 2);
    expect_issue({LD1, 8'hC2}, s + 3);
    expect_issue({LD2, 8'hC3}, s + 4);
    pulse_start();
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t6_stop_busy", 32'(busy), 32'd0);
    check("t6_stop_inst_en", 32'(inst_en), 32'd0);
    check("t6_stop_pc", 32'(pc), 32'd3);
    repeat (3) step();
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
